// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the dm_responder memory slave.
package dm_responder_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte address range served by the responder (4 KB)
  localparam logic [31:0] ADDR_RANGE = 32'h0000_1000;

  // Wait-state counter width; holds WAIT_CYC-1 for WAIT_CYC up to 15
  localparam int CNT_W = 4;

  // A request is rejected when it is not word aligned or falls outside the range
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= ADDR_RANGE);
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Contents are not reset: they survive rst and are undefined after power-up.
module dm_word_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write or synchronous read; rdata only moves on a read access
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding request/response memory slave with programmable wait states.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request (req_ready=1)
// WAIT    | request latched, counting down wait states
// RESP    | access done, response held until rsp_ready
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int WAIT_CYC = 2,
  parameter int DEPTH    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              accept;
  logic              access;
  logic              acc_wr;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              ram_en;
  logic [31:0]       ram_rdata;
  logic              err_q;

  assign accept = req_valid & req_ready;

  // With no wait states the access happens on the accept edge itself, before
  // the request registers are loaded, so take the fields straight from the bus.
  assign acc_wr    = (state_q == ST_IDLE) ? req_wr    : wr_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;

  // Gating with rst keeps a request presented during reset from touching memory
  assign ram_en = access & ~addr_bad(acc_addr) & rst;

  dm_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (acc_wr),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (ram_rdata)
  );

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Next-state, counter and access strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    access    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYC == 0) begin
            state_d = ST_RESP;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Response outputs decode from registered state; the RAM read port is only
  // updated when entering RESP, so the load data stays put while RESP is held.
  assign err_q     = addr_bad(addr_q);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? ram_rdata : 32'h0;

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 2, meaning wait states inserted between request acceptance and memory access (legal range 0..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words of storage (4 KB).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_wr  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-017 On acceptance SHALL latch req_wr, req_addr, req_wdata and req_be, then go to WAIT with counter=WAIT_CYC-1, or directly to RESP if WAIT_CYC=0.
REQ-018 In WAIT SHALL decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-019 SHALL perform the memory access on the edge entering RESP, so rsp_valid rises exactly WAIT_CYC+1 cycles after the accept edge.
REQ-020 Load: rsp_rdata SHALL equal mem[addr[11:2]] as of that edge.
REQ-021 Store: SHALL write only the enabled byte lanes; be=4'b0000 SHALL still complete with a response and change no memory.
REQ-022 Error: a request with addr[1:0]!=0 or addr[31:12]!=0 SHALL not access memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, which returns the FSM to IDLE.
REQ-024 SHALL NOT accept a new request in the same cycle its response completes; at most one request is in flight.
REQ-025 Outside RESP, rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-026 A load issued after a completed store to the same word SHALL return the merged stored data.

Reset
REQ-027 Asserting rst (low) at any time, including mid-transaction, SHALL immediately force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-028 Reset SHALL drop any in-flight transaction with no memory write.
REQ-029 Reset SHALL leave memory contents unchanged; they are undefined after power-up.

Structure
REQ-030 State encodings for IDLE, WAIT and RESP and the address-range constant (4 KB) SHALL live in a shared package.
REQ-031 Storage SHALL be one sub-module, dm_word_ram, with byte-enabled write and synchronous read.

Verification
REQ-032 WAIT_CYC=2: store addr 0x10, data 0xDEADBEEF, be 1111, then load 0x10 -> rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF with rsp_err=0.
REQ-033 Store 0x11223344 to 0x20 with be 0101 over prior 0xAAAAAAAA -> later load of 0x20 returns 0xAA22AA44.
REQ-034 Load 0x22 and load 0x1000 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout, req_ready=0; FSM returns to IDLE one edge after rsp_ready=1.
REQ-036 WAIT_CYC=0: back-to-back loads -> each response 1 cycle after accept; req_ready low during RESP.
REQ-037 Assert rst during WAIT of a store to 0x30 -> req_ready=1 and rsp_valid=0 immediately; later load of 0x30 returns the old data.
